// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned DEF_ADDR_W         = 16;
    localparam int unsigned DEF_DATA_W         = 16;
    localparam logic [15:0] DEF_RESET_PC       = 16'h0000;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 255;

    // Width of the mem_ready wait counter; TIMEOUT_CYCLES must fit in it.
    localparam int unsigned TMO_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        LOAD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter register: synchronous reset, load has priority over increment.
module pc_reg
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_val;
        end else if (inc) begin
            pc <= pc + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, runs the instruction-memory read handshake and loads the IR.
// Optional mem_ready timeout is enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = DEF_ADDR_W,
    parameter int unsigned       DATA_W   = DEF_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
`ifdef FETCH_TIMEOUT_EN
    ,
    parameter int unsigned       TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_val,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              ir_en,
    output logic [DATA_W-1:0] ir_data,
    output logic              fetch_done,
    output logic              busy,
    output logic [ADDR_W-1:0] pc,
    output logic              fetch_err
);

    fetch_state_t      state, state_nxt;
    logic              pend_vld;
    logic [ADDR_W-1:0] pend_addr;
    logic              pc_ld, pc_inc, ir_cap, tmo_hit;
    logic [ADDR_W-1:0] pc_ld_val;
    logic              redir;
    logic [ADDR_W-1:0] redir_tgt;

    pc_reg #(
        .ADDR_W  (ADDR_W),
        .RESET_PC(RESET_PC)
    ) u_pc_reg (
        .clk     (clk),
        .rst     (rst),
        .load    (pc_ld),
        .load_val(pc_ld_val),
        .inc     (pc_inc),
        .pc      (pc)
    );

    assign mem_addr = pc;

    // A strobe in the current cycle is the newest redirect and beats the latched one.
    assign redir     = pc_load | pend_vld;
    assign redir_tgt = pc_load ? pc_load_val : pend_addr;

`ifdef FETCH_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_cnt;

    always_ff @(posedge clk) begin
        if (rst || state != REQ) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    assign tmo_hit = (state == REQ) && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_err <= 1'b0;
        end else begin
            fetch_err <= tmo_hit && !mem_ready;
        end
    end
`else
    assign tmo_hit   = 1'b0;
    assign fetch_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_ld     = 1'b0;
        pc_ld_val = pc_load_val;
        pc_inc    = 1'b0;
        ir_cap    = 1'b0;
        case (state)
            IDLE: begin
                if (pc_load) begin
                    pc_ld = 1'b1;
                end else if (fetch_req) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (mem_ready) begin
                    if (redir) begin
                        pc_ld     = 1'b1;
                        pc_ld_val = redir_tgt;
                        state_nxt = IDLE;
                    end else begin
                        pc_inc    = 1'b1;
                        ir_cap    = 1'b1;
                        state_nxt = LOAD;
                    end
                end else if (tmo_hit) begin
                    pc_ld     = redir;
                    pc_ld_val = redir_tgt;
                    state_nxt = IDLE;
                end
            end
            LOAD: begin
                pc_ld     = pc_load;
                state_nxt = fetch_req ? REQ : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Redirect latch lives only while the read stays outstanding in REQ.
    always_ff @(posedge clk) begin
        if (rst || state_nxt != REQ) begin
            pend_vld  <= 1'b0;
            pend_addr <= '0;
        end else if (state == REQ && pc_load) begin
            pend_vld  <= 1'b1;
            pend_addr <= pc_load_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_rd     <= 1'b0;
            busy       <= 1'b0;
            ir_en      <= 1'b0;
            fetch_done <= 1'b0;
            ir_data    <= '0;
        end else begin
            mem_rd     <= (state_nxt == REQ);
            busy       <= (state_nxt == REQ);
            ir_en      <= (state_nxt == LOAD);
            fetch_done <= (state_nxt == LOAD);
            if (ir_cap) begin
                ir_data <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch; covers the timeout path when FETCH_TIMEOUT_EN is defined.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic        pc_load;
    logic [15:0] pc_load_val;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic        ir_en;
    logic [15:0] ir_data;
    logic        fetch_done;
    logic        busy;
    logic [15:0] pc;
    logic        fetch_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_fetch #(
        .RESET_PC(16'h0000)
`ifdef FETCH_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(4)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fetch_req  (fetch_req),
        .pc_load    (pc_load),
        .pc_load_val(pc_load_val),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .ir_en      (ir_en),
        .ir_data    (ir_data),
        .fetch_done (fetch_done),
        .busy       (busy),
        .pc         (pc),
        .fetch_err  (fetch_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; fetch_req = 1'b0; pc_load = 1'b0; pc_load_val = 16'h0000;
        mem_ready = 1'b0; mem_rdata = 16'h0000;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; fetch_req = 1'b0; pc_load = 1'b0; pc_load_val = 16'h0000;
        mem_ready = 1'b0; mem_rdata = 16'h0000;
        tick();
        tick();
        checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL reset_pc got %h exp %h", pc, 16'h0000); end
        checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL reset_mem_rd got %b exp 0", mem_rd); end
        checks++; if (ir_en !== 1'b0 || fetch_done !== 1'b0) begin errors++; $display("FAIL reset_ir_en got %b/%b exp 0/0", ir_en, fetch_done); end
        checks++; if (busy !== 1'b0 || fetch_err !== 1'b0) begin errors++; $display("FAIL reset_busy_err got %b/%b exp 0/0", busy, fetch_err); end
        checks++; if (ir_data !== 16'h0000) begin errors++; $display("FAIL reset_ir_data got %h exp 0000", ir_data); end
        rst = 1'b0;
    endtask

    task automatic test_single_fetch();
        do_reset();
        fetch_req = 1'b1;
        tick();
        checks++; if (mem_rd !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL single_req got rd=%b busy=%b exp 1/1", mem_rd, busy); end
        checks++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL single_addr got %h exp 0000", mem_addr); end
        checks++; if (ir_en !== 1'b0) begin errors++; $display("FAIL single_early_ir_en got %b exp 0", ir_en); end
        fetch_req = 1'b0; mem_ready = 1'b1; mem_rdata = 16'hA5C3;
        tick();
        mem_ready = 1'b0;
        checks++; if (ir_en !== 1'b1 || fetch_done !== 1'b1) begin errors++; $display("FAIL single_load got ir_en=%b done=%b exp 1/1", ir_en, fetch_done); end
        checks++; if (ir_data !== 16'hA5C3) begin errors++; $display("FAIL single_ir_data got %h exp a5c3", ir_data); end
        checks++; if (pc !== 16'h0001) begin errors++; $display("FAIL single_pc got %h exp 0001", pc); end
        checks++; if (mem_rd !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_load_rd got rd=%b busy=%b exp 0/0", mem_rd, busy); end
        tick();
        checks++; if (ir_en !== 1'b0 || fetch_done !== 1'b0 || mem_rd !== 1'b0) begin errors++; $display("FAIL single_idle got ir_en=%b done=%b rd=%b exp 0/0/0", ir_en, fetch_done, mem_rd); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        fetch_req = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++; if (mem_rd !== 1'b1 || mem_addr !== 16'(k)) begin errors++; $display("FAIL b2b_addr%0d got rd=%b addr=%h exp 1/%h", k, mem_rd, mem_addr, 16'(k)); end
            for (int w = 0; w < 3; w++) begin
                tick();
                checks++; if (mem_rd !== 1'b1 || ir_en !== 1'b0) begin errors++; $display("FAIL b2b_wait%0d_%0d got rd=%b ir_en=%b exp 1/0", k, w, mem_rd, ir_en); end
            end
            mem_ready = 1'b1; mem_rdata = 16'(k + 1);
            tick();
            mem_ready = 1'b0;
            checks++; if (ir_en !== 1'b1 || ir_data !== 16'(k + 1)) begin errors++; $display("FAIL b2b_load%0d got ir_en=%b data=%h exp 1/%h", k, ir_en, ir_data, 16'(k + 1)); end
            checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL b2b_load_rd%0d got %b exp 0", k, mem_rd); end
            if (k < 2) tick();
        end
        fetch_req = 1'b0;
        tick();
        checks++; if (pc !== 16'h0003 || mem_rd !== 1'b0 || ir_en !== 1'b0) begin errors++; $display("FAIL b2b_end got pc=%h rd=%b ir_en=%b exp 0003/0/0", pc, mem_rd, ir_en); end
    endtask

    task automatic test_wrap();
        do_reset();
        pc_load = 1'b1; pc_load_val = 16'hFFFF;
        tick();
        pc_load = 1'b0; fetch_req = 1'b1;
        checks++; if (pc !== 16'hFFFF || mem_rd !== 1'b0) begin errors++; $display("FAIL wrap_idle_load got pc=%h rd=%b exp ffff/0", pc, mem_rd); end
        tick();
        fetch_req = 1'b0; mem_ready = 1'b1; mem_rdata = 16'h1234;
        checks++; if (mem_rd !== 1'b1 || mem_addr !== 16'hFFFF) begin errors++; $display("FAIL wrap_addr got rd=%b addr=%h exp 1/ffff", mem_rd, mem_addr); end
        tick();
        mem_ready = 1'b0;
        checks++; if (pc !== 16'h0000 || ir_data !== 16'h1234 || ir_en !== 1'b1) begin errors++; $display("FAIL wrap_pc got pc=%h data=%h ir_en=%b exp 0000/1234/1", pc, ir_data, ir_en); end
        tick();
        // redirect and request together: redirect wins, fetch starts next cycle from the new pc
        pc_load = 1'b1; pc_load_val = 16'h0020; fetch_req = 1'b1;
        tick();
        pc_load = 1'b0;
        checks++; if (pc !== 16'h0020 || mem_rd !== 1'b0) begin errors++; $display("FAIL both_idle got pc=%h rd=%b exp 0020/0", pc, mem_rd); end
        tick();
        fetch_req = 1'b0; mem_ready = 1'b1; mem_rdata = 16'h0BAD;
        checks++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0020) begin errors++; $display("FAIL both_req got rd=%b addr=%h exp 1/0020", mem_rd, mem_addr); end
        tick();
        mem_ready = 1'b0;
        tick();
    endtask

    task automatic test_redirect();
        do_reset();
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0; pc_load = 1'b1; pc_load_val = 16'h0040;
        tick();
        pc_load_val = 16'h0080;
        checks++; if (mem_rd !== 1'b1 || pc !== 16'h0000) begin errors++; $display("FAIL redir_hold got rd=%b pc=%h exp 1/0000", mem_rd, pc); end
        tick();
        pc_load = 1'b0;
        tick();
        mem_ready = 1'b1; mem_rdata = 16'hBEEF;
        tick();
        mem_ready = 1'b0;
        checks++; if (ir_en !== 1'b0 || fetch_done !== 1'b0) begin errors++; $display("FAIL redir_no_ir_en got %b/%b exp 0/0", ir_en, fetch_done); end
        checks++; if (pc !== 16'h0080 || ir_data !== 16'h0000 || mem_rd !== 1'b0) begin errors++; $display("FAIL redir_pc got pc=%h data=%h rd=%b exp 0080/0000/0", pc, ir_data, mem_rd); end
        tick();
        checks++; if (mem_rd !== 1'b0 || ir_en !== 1'b0) begin errors++; $display("FAIL redir_idle got rd=%b ir_en=%b exp 0/0", mem_rd, ir_en); end
        // strobe coincident with mem_ready discards the data
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0; pc_load = 1'b1; pc_load_val = 16'h0100; mem_ready = 1'b1; mem_rdata = 16'h7777;
        tick();
        pc_load = 1'b0; mem_ready = 1'b0;
        checks++; if (ir_en !== 1'b0 || pc !== 16'h0100 || ir_data !== 16'h0000) begin errors++; $display("FAIL redir_same got ir_en=%b pc=%h data=%h exp 0/0100/0000", ir_en, pc, ir_data); end
    endtask

    task automatic test_load_redirect();
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0; mem_ready = 1'b1; mem_rdata = 16'h5555;
        tick();
        mem_ready = 1'b0; pc_load = 1'b1; pc_load_val = 16'h0200; fetch_req = 1'b1;
        checks++; if (ir_en !== 1'b1 || pc !== 16'h0101) begin errors++; $display("FAIL ldredir_load got ir_en=%b pc=%h exp 1/0101", ir_en, pc); end
        tick();
        pc_load = 1'b0; fetch_req = 1'b0; mem_ready = 1'b1; mem_rdata = 16'h6666;
        checks++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0200) begin errors++; $display("FAIL ldredir_req got rd=%b addr=%h exp 1/0200", mem_rd, mem_addr); end
        tick();
        mem_ready = 1'b0;
        checks++; if (ir_en !== 1'b1 || ir_data !== 16'h6666 || pc !== 16'h0201) begin errors++; $display("FAIL ldredir_next got ir_en=%b data=%h pc=%h exp 1/6666/0201", ir_en, ir_data, pc); end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        pc_load = 1'b1; pc_load_val = 16'h0300;
        tick();
        pc_load = 1'b0; fetch_req = 1'b1;
        tick();
        checks++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0300) begin errors++; $display("FAIL rstmid_req got rd=%b addr=%h exp 1/0300", mem_rd, mem_addr); end
        rst = 1'b1; fetch_req = 1'b0; mem_ready = 1'b1; mem_rdata = 16'h9999;
        tick();
        rst = 1'b0; mem_ready = 1'b0;
        checks++; if (mem_rd !== 1'b0 || pc !== 16'h0000) begin errors++; $display("FAIL rstmid got rd=%b pc=%h exp 0/0000", mem_rd, pc); end
        checks++; if (ir_en !== 1'b0 || ir_data !== 16'h0000) begin errors++; $display("FAIL rstmid_ir got ir_en=%b data=%h exp 0/0000", ir_en, ir_data); end
        tick();
        checks++; if (ir_en !== 1'b0 || mem_rd !== 1'b0) begin errors++; $display("FAIL rstmid_after got ir_en=%b rd=%b exp 0/0", ir_en, mem_rd); end
    endtask

    task automatic test_timeout();
        do_reset();
        pc_load = 1'b1; pc_load_val = 16'h0010;
        tick();
        pc_load = 1'b0; fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        for (int c = 1; c < 4; c++) begin
            checks++; if (mem_rd !== 1'b1 || fetch_err !== 1'b0) begin errors++; $display("FAIL tmo_wait%0d got rd=%b err=%b exp 1/0", c, mem_rd, fetch_err); end
            tick();
        end
        checks++; if (mem_rd !== 1'b1 || fetch_err !== 1'b0) begin errors++; $display("FAIL tmo_wait4 got rd=%b err=%b exp 1/0", mem_rd, fetch_err); end
        tick();
        checks++; if (fetch_err !== 1'b1 || mem_rd !== 1'b0 || pc !== 16'h0010) begin errors++; $display("FAIL tmo_fire got err=%b rd=%b pc=%h exp 1/0/0010", fetch_err, mem_rd, pc); end
        tick();
        checks++; if (fetch_err !== 1'b0 || mem_rd !== 1'b0 || ir_en !== 1'b0) begin errors++; $display("FAIL tmo_after got err=%b rd=%b ir_en=%b exp 0/0/0", fetch_err, mem_rd, ir_en); end
`else
        for (int c = 0; c < 22; c++) begin
            checks++; if (mem_rd !== 1'b1 || fetch_err !== 1'b0 || pc !== 16'h0010) begin errors++; $display("FAIL notmo_wait%0d got rd=%b err=%b pc=%h exp 1/0/0010", c, mem_rd, fetch_err, pc); end
            tick();
        end
        mem_ready = 1'b1; mem_rdata = 16'hCAFE;
        tick();
        mem_ready = 1'b0;
        checks++; if (ir_en !== 1'b1 || ir_data !== 16'hCAFE || pc !== 16'h0011) begin errors++; $display("FAIL notmo_done got ir_en=%b data=%h pc=%h exp 1/cafe/0011", ir_en, ir_data, pc); end
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "tb_instr_fetch watchdog");
    end

    initial begin
        test_reset();
        test_single_fetch();
        test_back_to_back();
        test_wrap();
        test_redirect();
        test_load_redirect();
        test_reset_mid();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
